// File: rtl/audio_clock_recovery.sv
// HDMI sink Audio Clock Regeneration: validates ACR packets, qualifies lock on a stable N,
// and regenerates a 128*fs clock enable plus an fs tick from f_pixel*N/CTS.
module audio_clock_recovery #(
  parameter int unsigned STABLE_COUNT   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned ERR_WIDTH      = 8
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 packet_valid,
  input  logic [23:0]          header,
  input  logic [3:0][55:0]     sub,
  output logic [19:0]          n_value,
  output logic [19:0]          cts_value,
  output logic                 locked,
  output logic                 clk_audio_en,
  output logic                 fs_tick,
  output logic [ERR_WIDTH-1:0] packet_errors
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned SW = $clog2(STABLE_COUNT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  state_t        state;
  logic [19:0]   cand;
  logic [SW-1:0] stable;
  logic [TW-1:0] tmo;
  logic [20:0]   acc;
  logic [6:0]    div;

  // Packet field extraction and validation
  logic [55:0] sp;
  logic [19:0] pkt_n;
  logic [19:0] pkt_cts;
  logic        copies_same;
  logic        rsv_zero;
  logic        is_acr;
  logic        fields_ok;
  logic        pkt_good;
  logic        pkt_bad;
  logic        unused_hdr;

  assign sp          = sub[0];
  assign pkt_n       = {sp[35:32], sp[47:40], sp[55:48]};
  assign pkt_cts     = {sp[11:8], sp[23:16], sp[31:24]};
  assign copies_same = (sub[0] == sub[1]) && (sub[1] == sub[2]) && (sub[2] == sub[3]);
  assign rsv_zero    = (sp[39:36] == 4'h0) && (sp[15:12] == 4'h0) && (sp[7:0] == 8'h00);
  assign is_acr      = packet_valid && (header[7:0] == 8'h01);
  assign fields_ok   = copies_same && rsv_zero && (pkt_n != '0) && (pkt_cts != '0) &&
                       (pkt_n < pkt_cts);
  assign pkt_good    = is_acr && fields_ok;
  assign pkt_bad     = is_acr && !fields_ok;
  assign unused_hdr  = ^header[23:8];

  // Fractional accumulator step; N < CTS guarantees at most one wrap per cycle
  logic [20:0] sum;
  logic        step_pulse;
  logic [20:0] acc_step;

  assign sum        = acc + {1'b0, n_value};
  assign step_pulse = (sum >= {1'b0, cts_value});
  assign acc_step   = step_pulse ? (sum - {1'b0, cts_value}) : sum;

  logic lock_now;
  assign lock_now = pkt_good &&
                    (((state == UNLOCKED) && (STABLE_COUNT <= 1)) ||
                     ((state == ACQUIRE) && (pkt_n == cand) &&
                      ((32'(stable) + 32'd1) >= STABLE_COUNT)));

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state         <= UNLOCKED;
      cand          <= '0;
      stable        <= '0;
      tmo           <= '0;
      acc           <= '0;
      div           <= '0;
      n_value       <= '0;
      cts_value     <= '0;
      locked        <= 1'b0;
      clk_audio_en  <= 1'b0;
      fs_tick       <= 1'b0;
      packet_errors <= '0;
    end else begin
      if (pkt_bad && (packet_errors != '1)) packet_errors <= packet_errors + ERR_WIDTH'(1);

      clk_audio_en <= 1'b0;
      fs_tick      <= 1'b0;
      if (state == LOCKED) begin
        acc <= acc_step;
        if (step_pulse) begin
          clk_audio_en <= 1'b1;
          fs_tick      <= (div == 7'd127);
          div          <= div + 7'd1;
        end
      end

      if (pkt_good) begin
        tmo <= '0;
        if (lock_now) begin
          state     <= LOCKED;
          locked    <= 1'b1;
          n_value   <= pkt_n;
          cts_value <= pkt_cts;
          acc       <= '0;
          div       <= '0;
        end else if ((state == LOCKED) && (pkt_n == n_value)) begin
          // CTS jitter: follow it, and keep acc below the new modulus
          cts_value <= pkt_cts;
          if (acc_step >= {1'b0, pkt_cts}) acc <= '0;
        end else if ((state == ACQUIRE) && (pkt_n == cand)) begin
          stable <= stable + SW'(1);
        end else begin
          state  <= ACQUIRE;
          cand   <= pkt_n;
          stable <= SW'(1);
          if (state == LOCKED) begin
            locked       <= 1'b0;
            acc          <= '0;
            div          <= '0;
            clk_audio_en <= 1'b0;
            fs_tick      <= 1'b0;
          end
        end
      end else if (tmo == TMO_LAST) begin
        state        <= UNLOCKED;
        locked       <= 1'b0;
        acc          <= '0;
        div          <= '0;
        clk_audio_en <= 1'b0;
        fs_tick      <= 1'b0;
      end else begin
        tmo <= tmo + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_audio_clock_recovery.sv
// Randomized scoreboard bench for audio_clock_recovery: a rule-level model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_audio_clock_recovery;

  localparam int STABLE  = 3;
  localparam int TMO     = 3000;
  localparam int ERR_W   = 4;
  localparam int ERR_MAX = 15;

  localparam int K_OK    = 0;  // well-formed ACR packet (validity still depends on N/CTS)
  localparam int K_MIS   = 1;  // one subpacket copy differs
  localparam int K_RSV   = 2;  // a reserved bit set in all copies
  localparam int K_OTHER = 3;  // packet type 0x02

  localparam int S_UNL  = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;

  typedef struct packed {
    logic [19:0]      n;
    logic [19:0]      cts;
    logic             lk;
    logic             en;
    logic             fs;
    logic [ERR_W-1:0] err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             packet_valid = 1'b0;
  logic [23:0]      header = '0;
  logic [3:0][55:0] sub = '0;
  logic [19:0]      n_value;
  logic [19:0]      cts_value;
  logic             locked;
  logic             clk_audio_en;
  logic             fs_tick;
  logic [ERR_W-1:0] packet_errors;

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];

  audio_clock_recovery #(
    .STABLE_COUNT(STABLE), .TIMEOUT_CYCLES(TMO), .ERR_WIDTH(ERR_W)
  ) dut (
    .clk_pixel(clk), .reset(reset), .packet_valid(packet_valid), .header(header), .sub(sub),
    .n_value(n_value), .cts_value(cts_value), .locked(locked), .clk_audio_en(clk_audio_en),
    .fs_tick(fs_tick), .packet_errors(packet_errors)
  );

  always #5 clk = ~clk;

  // Reference model state
  int ms = S_UNL, mcand = 0, mcnt = 0, mn = 0, mcts = 0, macc = 0, mtmo = 0, mdiv = 0, merr = 0;
  bit men = 1'b0, mfs = 1'b0;

  function automatic logic [55:0] enc(input logic [19:0] n, input logic [19:0] c);
    return {n[7:0], n[15:8], 4'h0, n[19:16], c[7:0], c[15:8], 4'h0, c[19:16], 8'h00};
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.n   = 20'(mn);
    e.cts = 20'(mcts);
    e.lk  = (ms == S_LOCK);
    e.en  = men;
    e.fs  = mfs;
    e.err = ERR_W'(merr);
    return e;
  endfunction

  task automatic drop_lock();
    macc = 0; mdiv = 0; men = 1'b0; mfs = 1'b0;
  endtask

  task automatic model_step(input bit rst, input bit pv, input int kind, input int n, input int c);
    bit acr, good;
    if (rst) begin
      ms = S_UNL; mcand = 0; mcnt = 0; mn = 0; mcts = 0; macc = 0; mtmo = 0; mdiv = 0; merr = 0;
      men = 1'b0; mfs = 1'b0;
      return;
    end
    acr  = pv && (kind != K_OTHER);
    good = acr && (kind != K_MIS) && (kind != K_RSV) && n != 0 && c != 0 && n < c;
    if (acr && !good && merr < ERR_MAX) merr++;
    men = 1'b0; mfs = 1'b0;
    if (ms == S_LOCK) begin
      // phase advances by N per pixel clock; each whole CTS is one 128*fs edge
      macc += mn;
      if (macc >= mcts) begin
        macc -= mcts; men = 1'b1; mfs = (mdiv == 127); mdiv = (mdiv + 1) % 128;
      end
    end
    if (good) begin
      mtmo = 0;
      if (ms == S_UNL) begin
        mcand = n; mcnt = 1; ms = S_ACQ;
      end else if (ms == S_ACQ) begin
        if (n == mcand) begin
          mcnt++;
          if (mcnt >= STABLE) begin ms = S_LOCK; mn = n; mcts = c; macc = 0; mdiv = 0; end
        end else begin
          mcand = n; mcnt = 1;
        end
      end else if (n == mn) begin
        mcts = c;
        if (macc >= c) macc = 0;
      end else begin
        ms = S_ACQ; mcand = n; mcnt = 1; drop_lock();
      end
    end else if (mtmo == TMO - 1) begin
      ms = S_UNL; drop_lock();
    end else begin
      mtmo++;
    end
  endtask

  // One clock of stimulus: record the outputs expected this cycle, then apply inputs
  task automatic cycle(input bit rst, input bit pv, input int kind, input int n, input int c);
    logic [55:0]      w;
    logic [3:0][55:0] s;
    int idx, b, r, pos;
    @(posedge clk); #1;
    exp_q.push_back(model_out());
    w = enc(20'(n), 20'(c));
    s = {w, w, w, w};
    if (kind == K_MIS) begin
      idx = $urandom_range(1, 3);
      b   = $urandom_range(0, 55);
      s[idx][b] = ~s[idx][b];
    end else if (kind == K_RSV) begin
      r   = $urandom_range(0, 15);
      pos = (r < 4) ? 36 + r : (r < 8) ? 12 + (r - 4) : r - 8;
      for (int i = 0; i < 4; i++) s[i][pos] = 1'b1;
    end
    reset        = rst;
    packet_valid = pv;
    header       = {16'($urandom), (kind == K_OTHER) ? 8'h02 : 8'h01};
    sub          = s;
    model_step(rst, pv, kind, n, c);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, K_OK, 0, 0);
  endtask

  task automatic send(input int kind, input int n, input int c);
    cycle(1'b0, 1'b1, kind, n, c);
  endtask

  task automatic lock_on(input int n, input int c, input int gap);
    for (int i = 0; i < STABLE; i++) begin send(K_OK, n, c); idle(gap); end
  endtask

  // Monitor: compare DUT outputs each cycle against the scoreboard
  initial begin
    int cyc;
    exp_t e, a;
    cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a.n = n_value; a.cts = cts_value; a.lk = locked; a.en = clk_audio_en;
        a.fs = fs_tick; a.err = packet_errors;
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL outputs cycle %0d: got n=%0d cts=%0d lk=%b en=%b fs=%b err=%0d, want n=%0d cts=%0d lk=%b en=%b fs=%b err=%0d",
                   cyc, a.n, a.cts, a.lk, a.en, a.fs, a.err, e.n, e.cts, e.lk, e.en, e.fs, e.err);
        end
      end
    end
  end

  initial begin
    int pulses, gap, r, kind, n, c;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, K_OK, 0, 0);
    idle(5);

    // Acquire and lock on N=61, CTS=252
    lock_on(61, 252, 251);
    idle(20);

    // Over exactly CTS cycles the enable count must equal N
    pulses = 0;
    for (int i = 0; i < 252; i++) begin
      idle(1);
      @(negedge clk);
      if (clk_audio_en) pulses++;
    end
    tests++;
    if (pulses != 61) begin
      fails++;
      $display("FAIL enable_rate_window: got %0d pulses, want 61", pulses);
    end

    // CTS jitter while locked
    for (int i = 0; i < 6; i++) begin send(K_OK, 61, (i % 2) ? 253 : 251); idle(200); end

    // Rejected packets, N==CTS boundary, non-ACR type, then error saturation
    send(K_MIS, 61, 252);   idle(10);
    send(K_OK, 300, 252);   idle(10);
    send(K_OK, 0, 252);     send(K_OK, 61, 0);
    send(K_RSV, 61, 252);   send(K_OTHER, 61, 252);
    send(K_OK, 252, 252);   idle(10);
    for (int i = 0; i < 15; i++) begin send(K_MIS, 61, 252); idle(3); end

    // N change: drop to acquire, relock on the new N
    send(K_OK, 55, 252); idle(100);
    send(K_OK, 55, 252); idle(100);
    send(K_OK, 55, 252); idle(300);

    // Near full-scale N and CTS exercise the 21-bit sum
    lock_on(1000000, 1048575, 50);
    idle(300);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      r    = $urandom_range(0, 9);
      n    = ($urandom_range(0, 3) == 0) ? 55 : 61;
      c    = $urandom_range(62, 400);
      kind = (r == 0) ? K_MIS : (r == 1) ? K_RSV : (r == 2) ? K_OTHER : K_OK;
      if (r == 3) n = c + $urandom_range(0, 5);
      send(kind, n, c);
      gap = $urandom_range(20, 300);
      idle(gap);
    end

    // Timeout back to unlocked
    lock_on(61, 252, 100);
    idle(TMO + 100);

    // Reset while locked; a packet in the reset cycle is discarded
    lock_on(61, 252, 100);
    idle(100);
    cycle(1'b1, 1'b1, K_OK, 61, 252);
    idle(50);
    send(K_OK, 61, 252); idle(100);
    send(K_OK, 61, 252); idle(100);
    send(K_OK, 61, 252); idle(300);

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/audio_clock_recovery.md
Name: audio_clock_recovery

Overview:
- Sink-side counterpart of the HDMI Audio Clock Regeneration (ACR) packet generator. Runs in the clk_pixel domain of the receive path.
- Accepts decoded data-island packets and validates ACR packets (type 0x01). Extracts N and CTS, and qualifies lock on a stable N.
- Regenerates a 128·fs clock-enable with a fractional accumulator: enable rate = f_pixel·N/CTS.
- Feeds the audio sample FIFO read side and the I2S/PCM output timing.

Parameters:
- STABLE_COUNT, 3: consecutive valid ACR packets with identical N required to enter LOCKED.
- TIMEOUT_CYCLES, 100000: clk_pixel cycles without a valid ACR packet before dropping to UNLOCKED.
- ERR_WIDTH, 8: width of the saturating packet error counter.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- packet_valid  in  1  single-cycle strobe; header/sub are valid this cycle.
- header  in  24  packet header; [7:0] = packet type.
- sub  in  4x56  subpackets sub[3:0].
- n_value  out  20  locked N.
- cts_value  out  20  most recent accepted CTS.
- locked  out  1  high in LOCKED state.
- clk_audio_en  out  1  one-cycle pulse at 128·fs.
- fs_tick  out  1  one-cycle pulse every 128 clk_audio_en pulses.
- packet_errors  out  ERR_WIDTH  saturating count of rejected ACR packets.

Behaviour:
- Reset values: all outputs 0, state UNLOCKED, accumulator 0, timeout counter 0, stable counter 0, /128 counter 0.
- Subpacket layout, MSB first: [55:48]=N[7:0], [47:40]=N[15:8], [39:36]=0, [35:32]=N[19:16], [31:24]=CTS[7:0], [23:16]=CTS[15:8], [15:12]=0, [11:8]=CTS[19:16], [7:0]=0.
- Non-ACR packets: a packet with packet_valid and header[7:0]!=8'h01 is ignored. It is not counted as an error and does not reset the timeout.
- ACR packet valid only if all of the following hold:
  - sub[0]==sub[1]==sub[2]==sub[3];
  - reserved nibbles and the [7:0] byte are zero;
  - N!=0 and CTS!=0;
  - N<CTS.
  - header[23:8] is ignored.
- Invalid ACR packet: packet_errors increments, saturating at all-ones. No other state change occurs and the timeout is not reset.
- Valid ACR packet: the timeout counter clears. Register updates appear at cycle t+1 after strobe cycle t.
- State machine (UNLOCKED / ACQUIRE / LOCKED):
  - UNLOCKED: on a valid packet, capture cand_N, set stable count=1, go to ACQUIRE. If STABLE_COUNT==1, go directly to LOCKED.
  - ACQUIRE: if a valid packet has N==cand_N, stable count+1. When the count reaches STABLE_COUNT, go to LOCKED: n_value<=N, cts_value<=CTS, accumulator<=0. If a valid packet has N!=cand_N, recapture cand_N and set count=1.
  - LOCKED: if a valid packet has N==n_value, cts_value<=CTS; CTS jitter is normal. If a valid packet has N!=n_value, go to ACQUIRE with cand_N=new N and count=1; n_value and cts_value hold their last values.
  - Any state: when the timeout counter reaches TIMEOUT_CYCLES-1 without a valid packet, go to UNLOCKED. The timeout counter saturates.
  - Leaving LOCKED for any reason: accumulator clears, the /128 counter clears, and clk_audio_en/fs_tick are forced 0 from the next cycle.
- Accumulator (21-bit, LOCKED only), each cycle:
  - sum = acc + n_value.
  - If sum >= cts_value: acc<=sum-cts_value and clk_audio_en<=1 (registered).
  - Else: acc<=sum and clk_audio_en<=0.
  - Invariant: acc < cts_value. Because N<CTS, at most one pulse occurs per cycle.
- CTS update in LOCKED: if acc >= new CTS, acc<=0 in the same update cycle. The accumulate step for that cycle uses the old CTS.
- fs_tick: a 7-bit counter increments on each clk_audio_en. fs_tick pulses coincident with the clk_audio_en that wraps the counter 127->0.
- Reset mid-operation: returns to reset values on the next edge. Any packet strobed in the reset cycle is discarded.

Test Plan:
1. Three valid packets N=6144, CTS=25200, each 25200 cycles apart -> locked=1 one cycle after the 3rd strobe; the first clk_audio_en occurs on the 5th locked cycle (acc 30720-25200=5520).
2. After lock, count over exactly 25200 cycles -> exactly 6144 clk_audio_en pulses and 48 fs_tick pulses; packet_errors=0.
3. While locked, send packets with CTS alternating 25199/25201 and N=6144 -> locked stays 1; cts_value follows each packet; the mean enable rate is unchanged.
4. Send a packet with sub[2] differing in one bit, then one with N=30000 and CTS=25200 -> packet_errors goes 0->1->2; state and outputs are unchanged. A type-0x02 packet leaves packet_errors unchanged.
5. While locked, send a valid packet with N=5880 -> state is ACQUIRE and clk_audio_en stops. Two more N=5880 packets -> relock with n_value=5880.
6. Stop packets for TIMEOUT_CYCLES -> locked=0 and no enables. Assert reset during LOCKED -> all outputs 0 on the next cycle, and 3 new packets are required to relock.
